// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared definitions for the two-port data-memory arbiter.
//   state_t          - arbiter FSM encoding (IDLE -> ACC -> RESP)
//   DEF_BASE_ADDR    - default byte address of RAM word 0
//   DEF_DEPTH_BYTES  - default RAM window size in bytes
//   PORT_M0/PORT_M1  - grant / pointer index of each requester
//   in_window()      - unsigned window check without wrap-around
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [31:0] DEF_BASE_ADDR   = 32'h1001_0000;
    localparam logic [31:0] DEF_DEPTH_BYTES = 32'h0000_1000;

    localparam logic PORT_M0 = 1'b0;
    localparam logic PORT_M1 = 1'b1;

    // 33-bit arithmetic so base+depth near the top of the address space
    // cannot wrap and falsely accept low addresses.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] depth);
        logic [32:0] a, lo, hi;
        a  = {1'b0, addr};
        lo = {1'b0, base};
        hi = {1'b0, base} + {1'b0, depth};
        return (a >= lo) && (a < hi);
    endfunction

endpackage

// File: rtl/dmem_arb_rr.sv
// dmem_arb_rr: combinational 2-way round-robin picker.
//   req  [1:0] - request per port (bit index = port index)
//   last       - port granted most recently
//   gnt        - selected port index (meaningful only when any req is set)
module dmem_arb_rr
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt
);

    always_comb begin
        gnt = PORT_M0;
        if (req[0] && req[1])
            gnt = ~last;          // tie: the port not served last time
        else if (req[1])
            gnt = PORT_M1;
        else
            gnt = PORT_M0;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: arbitrates a CPU port (m0) and a loader/debug port (m1)
// onto one single-cycle data RAM. Each access takes IDLE -> ACC -> RESP:
// the request is latched in IDLE, the RAM is enabled for the ACC cycle only,
// and the granted port gets a one-cycle ack (with err/rdata) in RESP.
//   clk, rst            - clock, synchronous active-high reset
//   mX_req/we/addr/wdata/size - requester inputs (X = 0, 1)
//   mX_ack/err/rdata    - completion pulse, out-of-window flag, read data
//   ram_ena/we/addr/switch/wdata, ram_rdata - RAM interface (offset address)
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
    parameter logic [31:0] DEPTH_BYTES = DEF_DEPTH_BYTES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [2:0]  m0_size,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [2:0]  m1_size,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_rdata,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_rdata,
    output logic        ram_ena,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [2:0]  ram_switch,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    state_t      state;
    logic        last_gnt;
    logic        gnt;
    logic        inwin_r;
    logic [31:0] rdata_r;

    logic        pick;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [2:0]  sel_size;
    logic        sel_inwin;

    dmem_arb_rr u_rr (
        .req  ({m1_req, m0_req}),
        .last (last_gnt),
        .gnt  (pick)
    );

    assign sel_we    = (pick == PORT_M1) ? m1_we    : m0_we;
    assign sel_addr  = (pick == PORT_M1) ? m1_addr  : m0_addr;
    assign sel_wdata = (pick == PORT_M1) ? m1_wdata : m0_wdata;
    assign sel_size  = (pick == PORT_M1) ? m1_size  : m0_size;
    assign sel_inwin = in_window(sel_addr, BASE_ADDR, DEPTH_BYTES);

    // One capture register serves both ports; the idle port's copy is
    // simply stale but always defined.
    assign m0_rdata = rdata_r;
    assign m1_rdata = rdata_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_gnt   <= PORT_M1;
            gnt        <= PORT_M0;
            inwin_r    <= 1'b0;
            rdata_r    <= 32'h0;
            ram_ena    <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= 32'h0;
            ram_wdata  <= 32'h0;
            ram_switch <= 3'h0;
            m0_ack     <= 1'b0;
            m0_err     <= 1'b0;
            m1_ack     <= 1'b0;
            m1_err     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (m0_req || m1_req) begin
                        // Everything the access needs is frozen here, so the
                        // requester may change or drop its inputs afterwards.
                        gnt        <= pick;
                        last_gnt   <= pick;
                        inwin_r    <= sel_inwin;
                        ram_addr   <= sel_addr - BASE_ADDR;
                        ram_wdata  <= sel_wdata;
                        ram_switch <= sel_size;
                        ram_ena    <= sel_inwin;
                        ram_we     <= sel_inwin & sel_we;
                        state      <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    ram_ena <= 1'b0;
                    ram_we  <= 1'b0;
                    rdata_r <= inwin_r ? ram_rdata : 32'h0;
                    m0_ack  <= (gnt == PORT_M0);
                    m1_ack  <= (gnt == PORT_M1);
                    m0_err  <= (gnt == PORT_M0) && !inwin_r;
                    m1_err  <= (gnt == PORT_M1) && !inwin_r;
                    state   <= ST_RESP;
                end
                ST_RESP: begin
                    m0_ack <= 1'b0;
                    m1_ack <= 1'b0;
                    m0_err <= 1'b0;
                    m1_err <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter. Inputs change and outputs are sampled on
// the falling edge; the DUT acts on the rising edge.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [2:0]  m0_size, m1_size;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        ram_ena, ram_we;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic [2:0]  ram_switch;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_size(m0_size),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_size(m1_size),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .ram_ena(ram_ena), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_switch(ram_switch), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_size = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_size = 0;
        ram_rdata = 32'hDEAD_BEEF;
        tick(); tick();
        rst = 1'b0;

        // reset state
        chk("rst_m0_ack", {31'b0, m0_ack}, 32'd0);
        chk("rst_m1_ack", {31'b0, m1_ack}, 32'd0);
        chk("rst_ram_ena", {31'b0, ram_ena}, 32'd0);
        chk("rst_ram_addr", ram_addr, 32'h0);
        chk("rst_rdata", m0_rdata, 32'h0);

        // m0 read in window: access at N+1, ack at N+2
        m0_req = 1; m0_we = 0; m0_addr = 32'h1001_0010; m0_size = 3'd2;
        tick();
        m0_req = 0;
        chk("rd_ram_ena", {31'b0, ram_ena}, 32'd1);
        chk("rd_ram_we", {31'b0, ram_we}, 32'd0);
        chk("rd_ram_addr", ram_addr, 32'h10);
        chk("rd_ram_switch", {29'b0, ram_switch}, 32'd2);
        chk("rd_early_ack", {31'b0, m0_ack}, 32'd0);
        tick();
        chk("rd_m0_ack", {31'b0, m0_ack}, 32'd1);
        chk("rd_m0_err", {31'b0, m0_err}, 32'd0);
        chk("rd_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
        chk("rd_m1_ack", {31'b0, m1_ack}, 32'd0);
        chk("rd_resp_ena", {31'b0, ram_ena}, 32'd0);
        tick();
        chk("rd_ack_pulse", {31'b0, m0_ack}, 32'd0);
        chk("rd_rdata_hold", m0_rdata, 32'hDEAD_BEEF);

        // fresh reset so the pointer favours m0, then continuous contention
        rst = 1'b1; tick(); rst = 1'b0;
        m0_req = 1; m0_we = 0; m0_addr = 32'h1001_0004;
        m1_req = 1; m1_we = 0; m1_addr = 32'h1001_0008;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k % 3 == 1) begin
                chk("rr_ram_ena", {31'b0, ram_ena}, 32'd1);
                chk("rr_ram_addr", ram_addr, (((k - 1) / 3) % 2 == 0) ? 32'h4 : 32'h8);
            end else if (k % 3 == 2) begin
                chk("rr_m0_ack", {31'b0, m0_ack}, (((k - 2) / 3) % 2 == 0) ? 32'd1 : 32'd0);
                chk("rr_m1_ack", {31'b0, m1_ack}, (((k - 2) / 3) % 2 == 1) ? 32'd1 : 32'd0);
            end else begin
                chk("rr_idle_ack", {30'b0, m1_ack, m0_ack}, 32'd0);
                chk("rr_idle_ena", {31'b0, ram_ena}, 32'd0);
            end
        end
        m0_req = 0; m1_req = 0;

        // m1 write to last word of window
        m1_req = 1; m1_we = 1; m1_addr = 32'h1001_0FFC; m1_wdata = 32'h1234_5678; m1_size = 3'd5;
        tick();
        m1_req = 0;
        chk("wr_ram_ena", {31'b0, ram_ena}, 32'd1);
        chk("wr_ram_we", {31'b0, ram_we}, 32'd1);
        chk("wr_ram_addr", ram_addr, 32'hFFC);
        chk("wr_ram_wdata", ram_wdata, 32'h1234_5678);
        chk("wr_ram_switch", {29'b0, ram_switch}, 32'd5);
        tick();
        chk("wr_m1_ack", {31'b0, m1_ack}, 32'd1);
        chk("wr_m1_err", {31'b0, m1_err}, 32'd0);
        chk("wr_m0_ack", {31'b0, m0_ack}, 32'd0);
        tick();

        // m1 write one past the window
        m1_req = 1; m1_addr = 32'h1001_1000;
        tick();
        m1_req = 0;
        chk("oow_hi_ena", {31'b0, ram_ena}, 32'd0);
        chk("oow_hi_we", {31'b0, ram_we}, 32'd0);
        tick();
        chk("oow_hi_ack", {31'b0, m1_ack}, 32'd1);
        chk("oow_hi_err", {31'b0, m1_err}, 32'd1);
        chk("oow_hi_rdata", m1_rdata, 32'h0);
        chk("oow_hi_ena2", {31'b0, ram_ena}, 32'd0);
        tick();

        // m0 reads below the window and near the top of the address space
        m0_req = 1; m0_we = 0; m0_addr = 32'h1000_FFFC;
        tick();
        m0_req = 0;
        chk("oow_lo_ena", {31'b0, ram_ena}, 32'd0);
        tick();
        chk("oow_lo_ack", {31'b0, m0_ack}, 32'd1);
        chk("oow_lo_err", {31'b0, m0_err}, 32'd1);
        chk("oow_lo_rdata", m0_rdata, 32'h0);
        tick();
        // restore a non-zero rdata so the next zero is meaningful
        m0_req = 1; m0_addr = 32'h1001_0000;
        tick(); m0_req = 0; tick();
        chk("inwin_rdata", m0_rdata, 32'hDEAD_BEEF);
        tick();
        m0_req = 1; m0_addr = 32'hFFFF_FFFC;
        tick();
        m0_req = 0;
        chk("oow_top_ena", {31'b0, ram_ena}, 32'd0);
        tick();
        chk("oow_top_ack", {31'b0, m0_ack}, 32'd1);
        chk("oow_top_err", {31'b0, m0_err}, 32'd1);
        chk("oow_top_rdata", m0_rdata, 32'h0);
        tick();

        // reset during ACC aborts the access; m0 then wins the first tie
        m0_req = 1; m0_addr = 32'h1001_0030;
        tick();
        chk("abort_acc_ena", {31'b0, ram_ena}, 32'd1);
        rst = 1'b1; m0_req = 0;
        tick();
        chk("abort_ena", {31'b0, ram_ena}, 32'd0);
        chk("abort_ack", {30'b0, m1_ack, m0_ack}, 32'd0);
        rst = 1'b0;
        m0_req = 1; m0_addr = 32'h1001_0020;
        m1_req = 1; m1_addr = 32'h1001_0040;
        tick();
        chk("abort_no_ack", {30'b0, m1_ack, m0_ack}, 32'd0);
        chk("post_rst_ena", {31'b0, ram_ena}, 32'd1);
        chk("post_rst_addr", ram_addr, 32'h20);
        tick();
        m0_req = 0; m1_req = 0;
        chk("post_rst_m0_ack", {31'b0, m0_ack}, 32'd1);
        chk("post_rst_m1_ack", {31'b0, m1_ack}, 32'd0);
        tick();

        // requester changes inputs and drops req mid-access
        m0_req = 1; m0_we = 1; m0_addr = 32'h1001_0100; m0_wdata = 32'hCAFE_0001; m0_size = 3'd1;
        tick();
        m0_req = 0; m0_addr = 32'h1001_0200; m0_wdata = 32'h0BAD_0BAD; m0_size = 3'd7;
        chk("hold_ena", {31'b0, ram_ena}, 32'd1);
        chk("hold_we", {31'b0, ram_we}, 32'd1);
        chk("hold_addr", ram_addr, 32'h100);
        chk("hold_wdata", ram_wdata, 32'hCAFE_0001);
        chk("hold_switch", {29'b0, ram_switch}, 32'd1);
        tick();
        chk("hold_ack", {31'b0, m0_ack}, 32'd1);
        chk("hold_err", {31'b0, m0_err}, 32'd0);
        chk("hold_resp_addr", ram_addr, 32'h100);
        tick();
        chk("hold_idle_ack", {31'b0, m0_ack}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
